// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I-subset control FSM.
package multicycle_ctrl_pkg;

  // FSM states; one instruction walks FETCH -> DECODE -> ... -> FETCH.
  typedef enum logic [3:0] {
    BOOT    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    EXEC_R  = 4'd3,
    EXEC_I  = 4'd4,
    ALU_WB  = 4'd5,
    MEM_ADR = 4'd6,
    MEM_RD  = 4'd7,
    MEM_WB  = 4'd8,
    MEM_WR  = 4'd9,
    BRANCH  = 4'd10,
    TRAP    = 4'd11
  } state_t;

  // Major opcodes as seen on instr[6:2] (instr[1:0] is always 2'b11 for RV32I).
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_BRANCH = 5'b11000;

  // ALU operations.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  // ALU operand A select.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B select.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format select.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  // Bundle of every datapath control; lets the output decoder start from '0.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic       reg_write;
    logic       result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_type;
    logic [2:0] alu_ctrl;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Maps {opcode, funct3, funct7} to an ALU operation and a legality flag
// for the supported subset (addi, add/sub, lw, sw, beq/bne).
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [2:0] alu_ctrl,
  output logic       legal
);

  // Per-opcode legality and ALU op; unsupported opcodes fall out as illegal.
  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE: begin
        // Address generation is always rs1 + imm; width is not checked.
        legal = 1'b1;
      end
      OP_OPIMM: begin
        legal = (funct3 == 3'b000);
      end
      OP_OP: begin
        legal    = (funct3 == 3'b000) && ((funct7 == 7'h00) || (funct7 == 7'h20));
        alu_ctrl = funct7[5] ? ALU_SUB : ALU_ADD;
      end
      OP_BRANCH: begin
        // Only beq (000) and bne (001); compare is done by subtracting.
        legal    = (funct3[2:1] == 2'b00);
        alu_ctrl = ALU_SUB;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory port. Outputs are a pure function of
// the current state, the instruction register and the eq/mem_ready inputs.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int IN_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IN_WIDTH-1:0] instr,
  input  logic                eq,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_we,
  output logic                pc_we,
  output logic                pc_src,
  output logic                reg_write,
  output logic                result_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          imm_type,
  output logic [2:0]          alu_ctrl,
  output logic                instr_done,
  output logic                illegal
);

  state_t     state, state_next;
  ctrl_t      c;
  logic [4:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [2:0] dec_alu_ctrl;
  logic       dec_legal;
  logic       taken;

  assign opcode = instr[6:2];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register specifiers, immediates and the low opcode bits belong to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[24:15], instr[11:7], instr[1:0]};

  alu_decoder u_alu_decoder (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .alu_ctrl (dec_alu_ctrl),
    .legal    (dec_legal)
  );

  // beq takes on equal, bne on not-equal; funct3[0] selects the sense.
  assign taken = eq ^ funct3[0];

  // State register; async clear drops any in-flight memory request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_next;
  end

  // Next-state sequencing; memory states stall on mem_ready, TRAP is terminal.
  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = FETCH;
      FETCH:   if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = MEM_ADR;
          OP_OP:             state_next = EXEC_R;
          OP_OPIMM:          state_next = EXEC_I;
          OP_BRANCH:         state_next = dec_legal ? BRANCH : TRAP;
          default:           state_next = TRAP;
        endcase
      end
      EXEC_R:  state_next = dec_legal ? ALU_WB : TRAP;
      EXEC_I:  state_next = dec_legal ? ALU_WB : TRAP;
      ALU_WB:  state_next = FETCH;
      MEM_ADR: state_next = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
      MEM_RD:  if (mem_ready) state_next = MEM_WB;
      MEM_WB:  state_next = FETCH;
      MEM_WR:  if (mem_ready) state_next = FETCH;
      BRANCH:  state_next = FETCH;
      TRAP:    state_next = TRAP;
      default: state_next = TRAP;
    endcase
  end

  // Output decode; every control defaults low so BOOT and TRAP are quiet.
  always_comb begin
    c = '0;
    case (state)
      FETCH: begin
        // Request/address stay constant while stalled; PC+4 and IR load only on ready.
        c.mem_req = 1'b1;
        c.iord    = 1'b0;
        if (mem_ready) begin
          c.ir_we     = 1'b1;
          c.pc_we     = 1'b1;
          c.pc_src    = 1'b0;
          c.alu_src_a = SRCA_PC;
          c.alu_src_b = SRCB_FOUR;
          c.alu_ctrl  = ALU_ADD;
        end
      end
      DECODE: begin
        // Speculatively form the branch target into ALUOut.
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.imm_type  = IMM_B;
        c.alu_ctrl  = ALU_ADD;
      end
      EXEC_R: begin
        if (dec_legal) begin
          c.alu_src_a = SRCA_RS1;
          c.alu_src_b = SRCB_RS2;
          c.alu_ctrl  = dec_alu_ctrl;
        end
      end
      EXEC_I: begin
        if (dec_legal) begin
          c.alu_src_a = SRCA_RS1;
          c.alu_src_b = SRCB_IMM;
          c.imm_type  = IMM_I;
          c.alu_ctrl  = dec_alu_ctrl;
        end
      end
      ALU_WB: begin
        c.reg_write  = 1'b1;
        c.result_src = 1'b0;
        c.instr_done = 1'b1;
      end
      MEM_ADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.imm_type  = (opcode == OP_STORE) ? IMM_S : IMM_I;
        c.alu_ctrl  = ALU_ADD;
      end
      MEM_RD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      MEM_WB: begin
        c.reg_write  = 1'b1;
        c.result_src = 1'b1;
        c.instr_done = 1'b1;
      end
      MEM_WR: begin
        c.mem_req    = 1'b1;
        c.mem_we     = 1'b1;
        c.iord       = 1'b1;
        c.instr_done = mem_ready;
      end
      BRANCH: begin
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_RS2;
        c.alu_ctrl   = dec_alu_ctrl;
        c.pc_we      = taken;
        c.pc_src     = 1'b1;
        c.instr_done = 1'b1;
      end
      TRAP: begin
        c.illegal = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
  end

  assign mem_req    = c.mem_req;
  assign mem_we     = c.mem_we;
  assign iord       = c.iord;
  assign ir_we      = c.ir_we;
  assign pc_we      = c.pc_we;
  assign pc_src     = c.pc_src;
  assign reg_write  = c.reg_write;
  assign result_src = c.result_src;
  assign alu_src_a  = c.alu_src_a;
  assign alu_src_b  = c.alu_src_b;
  assign imm_type   = c.imm_type;
  assign alu_ctrl   = c.alu_ctrl;
  assign instr_done = c.instr_done;
  assign illegal    = c.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected control vectors.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        eq;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_write, result_src;
  logic [1:0]  alu_src_a, alu_src_b, imm_type;
  logic [2:0]  alu_ctrl;
  logic        instr_done, illegal;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl #(.IN_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .eq(eq), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_type(imm_type),
    .alu_ctrl(alu_ctrl), .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {mem_req,mem_we,iord,ir_we,pc_we,pc_src,reg_write,result_src,src_a,src_b,imm,alu,done,illegal}
  logic [18:0] obs;
  assign obs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_write, result_src,
                alu_src_a, alu_src_b, imm_type, alu_ctrl, instr_done, illegal};

  localparam logic [18:0] ZERO    = 19'd0;
  localparam logic [18:0] F_WAIT  = {8'b1000_0000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] F_RDY   = {8'b1001_1000, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] DEC     = {8'b0000_0000, 2'b01, 2'b01, 2'b10, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] EXI     = {8'b0000_0000, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] EXR_ADD = {8'b0000_0000, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] EXR_SUB = {8'b0000_0000, 2'b10, 2'b00, 2'b00, 3'b001, 1'b0, 1'b0};
  localparam logic [18:0] ALUWB   = {8'b0000_0010, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0};
  localparam logic [18:0] MADR_L  = {8'b0000_0000, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] MADR_S  = {8'b0000_0000, 2'b10, 2'b01, 2'b01, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] MRD     = {8'b1010_0000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] MWB     = {8'b0000_0011, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0};
  localparam logic [18:0] MWR_W   = {8'b1110_0000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [18:0] MWR_R   = {8'b1110_0000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0};
  localparam logic [18:0] BR_T    = {8'b0000_1100, 2'b10, 2'b00, 2'b00, 3'b001, 1'b1, 1'b0};
  localparam logic [18:0] BR_N    = {8'b0000_0100, 2'b10, 2'b00, 2'b00, 3'b001, 1'b1, 1'b0};
  localparam logic [18:0] TRAPV   = {8'b0000_0000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1};

  localparam logic [31:0] I_ADDI   = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_ADD    = 32'h0020_81B3; // add  x3,x1,x2
  localparam logic [31:0] I_SUB    = 32'h4020_81B3; // sub  x3,x1,x2
  localparam logic [31:0] I_SUBBAD = 32'h2020_81B3; // funct7=0x10
  localparam logic [31:0] I_BNE    = 32'h0020_9463; // bne  x1,x2,8
  localparam logic [31:0] I_BEQ    = 32'h0020_8463; // beq  x1,x2,8
  localparam logic [31:0] I_LW     = 32'h0040_A183; // lw   x3,4(x1)
  localparam logic [31:0] I_SW     = 32'h0030_A423; // sw   x3,8(x1)
  localparam logic [31:0] I_ONES   = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] ins;
    logic        rdy;
    logic        eqv;
    logic [18:0] ex;
  } row_t;

  function automatic row_t r(input logic [31:0] ins, input logic rdy, input logic eqv,
                             input logic [18:0] ex);
    row_t t;
    t.ins = ins; t.rdy = rdy; t.eqv = eqv; t.ex = ex;
    return t;
  endfunction

  task automatic test_reset();
    instr = I_ADDI; mem_ready = 1'b1; eq = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (obs !== ZERO) begin
        bad++; $display("FAIL reset_hold cyc%0d got=%h want=%h", i, obs, ZERO);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    row_t rows[$];
    rows.push_back(r(I_ADDI, 1, 0, ZERO));   // BOOT
    rows.push_back(r(I_ADDI, 1, 0, F_RDY));
    rows.push_back(r(I_ADDI, 1, 0, DEC));
    rows.push_back(r(I_ADDI, 1, 0, EXI));
    rows.push_back(r(I_ADDI, 1, 0, ALUWB));
    foreach (rows[i]) begin
      instr = rows[i].ins; mem_ready = rows[i].rdy; eq = rows[i].eqv;
      @(negedge clk);
      total++;
      if (obs !== rows[i].ex) begin
        bad++; $display("FAIL addi cyc%0d got=%h want=%h", i, obs, rows[i].ex);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fetch_wait();
    row_t rows[$];
    rows.push_back(r(I_ADDI, 0, 0, F_WAIT));
    rows.push_back(r(I_ADDI, 0, 0, F_WAIT));
    rows.push_back(r(I_ADDI, 0, 0, F_WAIT));
    rows.push_back(r(I_ADDI, 1, 0, F_RDY));
    rows.push_back(r(I_ADDI, 0, 0, DEC));
    rows.push_back(r(I_ADDI, 0, 0, EXI));
    rows.push_back(r(I_ADDI, 0, 0, ALUWB));
    foreach (rows[i]) begin
      instr = rows[i].ins; mem_ready = rows[i].rdy; eq = rows[i].eqv;
      @(negedge clk);
      total++;
      if (obs !== rows[i].ex) begin
        bad++; $display("FAIL fetch_wait cyc%0d got=%h want=%h", i, obs, rows[i].ex);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_add_sub();
    row_t rows[$];
    rows.push_back(r(I_ADD, 1, 0, F_RDY));
    rows.push_back(r(I_ADD, 1, 0, DEC));
    rows.push_back(r(I_ADD, 1, 0, EXR_ADD));
    rows.push_back(r(I_ADD, 1, 0, ALUWB));
    rows.push_back(r(I_SUB, 1, 0, F_RDY));
    rows.push_back(r(I_SUB, 1, 0, DEC));
    rows.push_back(r(I_SUB, 1, 0, EXR_SUB));
    rows.push_back(r(I_SUB, 1, 0, ALUWB));
    foreach (rows[i]) begin
      instr = rows[i].ins; mem_ready = rows[i].rdy; eq = rows[i].eqv;
      @(negedge clk);
      total++;
      if (obs !== rows[i].ex) begin
        bad++; $display("FAIL add_sub cyc%0d got=%h want=%h", i, obs, rows[i].ex);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    row_t rows[$];
    rows.push_back(r(I_BNE, 1, 0, F_RDY));
    rows.push_back(r(I_BNE, 1, 0, DEC));
    rows.push_back(r(I_BNE, 1, 0, BR_T));  // bne, not equal: taken
    rows.push_back(r(I_BNE, 1, 1, F_RDY));
    rows.push_back(r(I_BNE, 1, 1, DEC));
    rows.push_back(r(I_BNE, 1, 1, BR_N));  // bne, equal: not taken
    rows.push_back(r(I_BEQ, 1, 0, F_RDY));
    rows.push_back(r(I_BEQ, 1, 0, DEC));
    rows.push_back(r(I_BEQ, 1, 0, BR_N));  // beq, not equal: not taken
    rows.push_back(r(I_BEQ, 1, 1, F_RDY));
    rows.push_back(r(I_BEQ, 1, 1, DEC));
    rows.push_back(r(I_BEQ, 1, 1, BR_T));  // beq, equal: taken
    foreach (rows[i]) begin
      instr = rows[i].ins; mem_ready = rows[i].rdy; eq = rows[i].eqv;
      @(negedge clk);
      total++;
      if (obs !== rows[i].ex) begin
        bad++; $display("FAIL branch cyc%0d got=%h want=%h", i, obs, rows[i].ex);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_store();
    row_t rows[$];
    int   done_cnt = 0;
    int   cyc_cnt  = 0;
    rows.push_back(r(I_LW, 1, 0, F_RDY));
    rows.push_back(r(I_LW, 0, 0, DEC));
    rows.push_back(r(I_LW, 0, 0, MADR_L));
    rows.push_back(r(I_LW, 0, 0, MRD));
    rows.push_back(r(I_LW, 0, 0, MRD));
    rows.push_back(r(I_LW, 1, 0, MRD));
    rows.push_back(r(I_LW, 0, 0, MWB));     // 7th cycle: lw complete
    rows.push_back(r(I_SW, 1, 0, F_RDY));
    rows.push_back(r(I_SW, 0, 0, DEC));
    rows.push_back(r(I_SW, 0, 0, MADR_S));
    rows.push_back(r(I_SW, 0, 0, MWR_W));
    rows.push_back(r(I_SW, 0, 0, MWR_W));
    rows.push_back(r(I_SW, 1, 0, MWR_R));   // 6th cycle: sw complete
    foreach (rows[i]) begin
      instr = rows[i].ins; mem_ready = rows[i].rdy; eq = rows[i].eqv;
      @(negedge clk);
      cyc_cnt++;
      if (instr_done === 1'b1) done_cnt++;
      total++;
      if (obs !== rows[i].ex) begin
        bad++; $display("FAIL load_store cyc%0d got=%h want=%h", i, obs, rows[i].ex);
      end
      @(posedge clk); #1;
    end
    total++;
    if (done_cnt !== 2 || cyc_cnt !== 13) begin
      bad++; $display("FAIL load_store_done got=%0d/%0d want=2/13", done_cnt, cyc_cnt);
    end
  endtask

  task automatic test_illegal();
    row_t rows[$];
    rows.push_back(r(I_ONES, 1, 0, F_RDY));
    rows.push_back(r(I_ONES, 1, 0, DEC));
    rows.push_back(r(I_ONES, 1, 0, TRAPV));
    rows.push_back(r(I_ADDI, 1, 1, TRAPV));  // sticky regardless of inputs
    rows.push_back(r(I_LW,   0, 0, TRAPV));
    foreach (rows[i]) begin
      instr = rows[i].ins; mem_ready = rows[i].rdy; eq = rows[i].eqv;
      @(negedge clk);
      total++;
      if (obs !== rows[i].ex) begin
        bad++; $display("FAIL illegal_ones cyc%0d got=%h want=%h", i, obs, rows[i].ex);
      end
      @(posedge clk); #1;
    end
    // Asynchronous reset clears illegal without waiting for a clock edge.
    rst_n = 1'b0; #1;
    total++;
    if (obs !== ZERO) begin
      bad++; $display("FAIL illegal_clear got=%h want=%h", obs, ZERO);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rows.delete();
    rows.push_back(r(I_SUBBAD, 1, 0, ZERO));  // BOOT
    rows.push_back(r(I_SUBBAD, 1, 0, F_RDY));
    rows.push_back(r(I_SUBBAD, 1, 0, DEC));
    rows.push_back(r(I_SUBBAD, 1, 0, ZERO));  // EXEC_R rejects funct7=0x10
    rows.push_back(r(I_SUBBAD, 1, 0, TRAPV));
    rows.push_back(r(I_ADD,    1, 0, TRAPV));
    foreach (rows[i]) begin
      instr = rows[i].ins; mem_ready = rows[i].rdy; eq = rows[i].eqv;
      @(negedge clk);
      total++;
      if (obs !== rows[i].ex) begin
        bad++; $display("FAIL illegal_funct7 cyc%0d got=%h want=%h", i, obs, rows[i].ex);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_req();
    row_t rows[$];
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rows.push_back(r(I_LW, 1, 0, ZERO));  // BOOT
    rows.push_back(r(I_LW, 1, 0, F_RDY));
    rows.push_back(r(I_LW, 0, 0, DEC));
    rows.push_back(r(I_LW, 0, 0, MADR_L));
    rows.push_back(r(I_LW, 0, 0, MRD));
    rows.push_back(r(I_LW, 0, 0, MRD));
    foreach (rows[i]) begin
      instr = rows[i].ins; mem_ready = rows[i].rdy; eq = rows[i].eqv;
      @(negedge clk);
      total++;
      if (obs !== rows[i].ex) begin
        bad++; $display("FAIL mid_req_pre cyc%0d got=%h want=%h", i, obs, rows[i].ex);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b1) begin
      bad++; $display("FAIL mid_req_held got=%b want=1", mem_req);
    end
    rst_n = 1'b0; #1;
    total++;
    if (mem_req !== 1'b0 || obs !== ZERO) begin
      bad++; $display("FAIL mid_req_drop got=%h want=%h", obs, ZERO);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rows.delete();
    rows.push_back(r(I_ADDI, 1, 0, ZERO));  // BOOT again
    rows.push_back(r(I_ADDI, 1, 0, F_RDY));
    rows.push_back(r(I_ADDI, 1, 0, DEC));
    rows.push_back(r(I_ADDI, 1, 0, EXI));
    rows.push_back(r(I_ADDI, 1, 0, ALUWB));
    foreach (rows[i]) begin
      instr = rows[i].ins; mem_ready = rows[i].rdy; eq = rows[i].eqv;
      @(negedge clk);
      total++;
      if (obs !== rows[i].ex) begin
        bad++; $display("FAIL mid_req_restart cyc%0d got=%h want=%h", i, obs, rows[i].ex);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; instr = 32'd0; eq = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_addi();
    test_fetch_wait();
    test_add_sub();
    test_branch();
    test_load_store();
    test_illegal();
    test_reset_mid_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
